// File: rtl/mealy_pattern_detector_if.sv
// Control/status bundle for mealy_pattern_detector: pattern load, qualified serial bit in,
// combinational match plus registered count/fill/state out.
interface mealy_pattern_detector_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic                       load;
    logic [PAT_W-1:0]           pattern_in;
    logic                       overlap;
    logic                       data_valid;
    logic                       data_in;
    logic                       match;
    logic [CNT_W-1:0]           match_count;
    logic [$clog2(PAT_W)-1:0]   fill;
    logic [1:0]                 estados;
    logic                       count_sat;

    modport master (
        output load, pattern_in, overlap, data_valid, data_in,
        input  match, match_count, fill, estados, count_sat
    );

    modport slave (
        input  load, pattern_in, overlap, data_valid, data_in,
        output match, match_count, fill, estados, count_sat
    );
endinterface

// File: rtl/mealy_pattern_detector.sv
// Serial pattern detector with runtime-loadable pattern; match is combinational (0 cycles)
// on the completing bit. No backpressure: bits are consumed whenever data_valid is high.
module mealy_pattern_detector #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    mealy_pattern_detector_if.slave bus
);
    localparam int              FW        = $clog2(PAT_W);
    localparam logic [1:0]      IDLE      = 2'b00;
    localparam logic [1:0]      FILL      = 2'b01;
    localparam logic [1:0]      HUNT      = 2'b10;
    localparam logic [FW-1:0]   FILL_LAST = FW'(PAT_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [1:0]         r_state;
    logic [PAT_W-1:0]   r_pat;
    logic               r_ovl;
    logic [PAT_W-2:0]   r_hist;
    logic [FW-1:0]      r_fill;
    logic [CNT_W-1:0]   r_count;
    logic               r_count_sat;

    logic [PAT_W-1:0]   w_candidate;
    logic               w_match;
    logic [FW-1:0]      w_fill_inc;
    logic [CNT_W-1:0]   w_count_next;

    assign w_candidate = {r_hist, bus.data_in};
    assign w_match     = (r_state == HUNT) & bus.data_valid & ~bus.load & (w_candidate == r_pat);
    assign w_fill_inc  = r_fill + FW'(1);

    always_comb begin
        w_count_next = r_count;
        if (bus.load)
            w_count_next = '0;
        else if (w_match && (r_count != CNT_MAX))
            w_count_next = r_count + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_pat       <= '0;
            r_ovl       <= 1'b0;
            r_hist      <= '0;
            r_fill      <= '0;
            r_count     <= '0;
            r_count_sat <= 1'b0;
        end else begin
            r_count     <= w_count_next;
            r_count_sat <= (w_count_next == CNT_MAX);
            if (bus.load) begin
                r_pat   <= bus.pattern_in;
                r_ovl   <= bus.overlap;
                r_hist  <= '0;
                r_fill  <= '0;
                r_state <= FILL;
            end else if (bus.data_valid) begin
                case (r_state)
                    FILL: begin
                        r_hist <= w_candidate[PAT_W-2:0];
                        r_fill <= w_fill_inc;
                        if (w_fill_inc == FILL_LAST)
                            r_state <= HUNT;
                    end
                    HUNT: begin
                        // Non-overlapping mode drops the completing bit and refills from scratch.
                        if (w_match && !r_ovl) begin
                            r_hist  <= '0;
                            r_fill  <= '0;
                            r_state <= FILL;
                        end else begin
                            r_hist <= w_candidate[PAT_W-2:0];
                        end
                    end
                    IDLE:    ;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.match       = w_match;
    assign bus.match_count = r_count;
    assign bus.fill        = r_fill;
    assign bus.estados     = r_state;
    assign bus.count_sat   = r_count_sat;
endmodule

// File: tb/tb_mealy_pattern_detector.sv
// Directed bench: a PAT_W=4/CNT_W=8 instance for detection modes, load and reset,
// and a PAT_W=2/CNT_W=2 instance for counter saturation.
module tb_mealy_pattern_detector;
    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mealy_pattern_detector_if #(.PAT_W(4), .CNT_W(8)) if4 ();
    mealy_pattern_detector_if #(.PAT_W(2), .CNT_W(2)) if2 ();

    mealy_pattern_detector #(.PAT_W(4), .CNT_W(8)) dut4 (.clk(clk), .reset_n(reset_n), .bus(if4));
    mealy_pattern_detector #(.PAT_W(2), .CNT_W(2)) dut2 (.clk(clk), .reset_n(reset_n), .bus(if2));

    int stream[7]     = '{1, 0, 1, 1, 0, 1, 1};
    int m_ovl[7]      = '{0, 0, 0, 1, 0, 0, 1};
    int st_ovl[7]     = '{1, 1, 2, 2, 2, 2, 2};
    int fill_ovl[7]   = '{1, 2, 3, 3, 3, 3, 3};
    int m_novl[7]     = '{0, 0, 0, 1, 0, 0, 0};
    int st_novl[7]    = '{1, 1, 2, 1, 1, 1, 2};
    int fill_novl[7]  = '{1, 2, 3, 0, 1, 2, 3};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle on the 4-bit instance; m is match sampled mid-cycle.
    task automatic step4(input logic l, input logic [3:0] p, input logic ov,
                         input logic dv, input logic di, output logic m);
        if4.load = l; if4.pattern_in = p; if4.overlap = ov;
        if4.data_valid = dv; if4.data_in = di;
        #2 m = if4.match;
        @(posedge clk); #1;
    endtask

    task automatic step2(input logic l, input logic [1:0] p, input logic ov,
                         input logic dv, input logic di, output logic m);
        if2.load = l; if2.pattern_in = p; if2.overlap = ov;
        if2.data_valid = dv; if2.data_in = di;
        #2 m = if2.match;
        @(posedge clk); #1;
    endtask

    initial begin
        logic m;
        reset_n = 1'b0;
        if4.load = 1'b0; if4.pattern_in = '0; if4.overlap = 1'b0; if4.data_valid = 1'b1; if4.data_in = 1'b1;
        if2.load = 1'b0; if2.pattern_in = '0; if2.overlap = 1'b0; if2.data_valid = 1'b0; if2.data_in = 1'b0;
        #1;
        check("rst_estados", if4.estados, 0);
        check("rst_count", if4.match_count, 0);
        check("rst_fill", if4.fill, 0);
        check("rst_match", if4.match, 0);
        check("rst_sat", if4.count_sat, 0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        step4(0, 4'b1011, 1, 1, 1, m);
        check("idle_match", m, 0);
        check("idle_estados", if4.estados, 0);
        check("idle_fill", if4.fill, 0);

        // Overlapping detection of 1011.
        step4(1, 4'b1011, 1, 0, 0, m);
        check("ovl_load_match", m, 0);
        check("ovl_load_estados", if4.estados, 1);
        for (int i = 0; i < 7; i++) begin
            step4(0, 4'b0000, 0, 1, stream[i][0], m);
            check($sformatf("ovl_m%0d", i + 1), m, m_ovl[i]);
            check($sformatf("ovl_st%0d", i + 1), if4.estados, st_ovl[i]);
            check($sformatf("ovl_fill%0d", i + 1), if4.fill, fill_ovl[i]);
        end
        check("ovl_count", if4.match_count, 2);

        // Non-overlapping detection.
        step4(1, 4'b1011, 0, 0, 0, m);
        check("novl_load_count", if4.match_count, 0);
        for (int i = 0; i < 7; i++) begin
            step4(0, 4'b0000, 1, 1, stream[i][0], m);
            check($sformatf("novl_m%0d", i + 1), m, m_novl[i]);
            check($sformatf("novl_st%0d", i + 1), if4.estados, st_novl[i]);
            check($sformatf("novl_fill%0d", i + 1), if4.fill, fill_novl[i]);
        end
        check("novl_count", if4.match_count, 1);

        // Gaps of data_valid=0 with data_in toggling.
        step4(1, 4'b1011, 1, 0, 0, m);
        for (int i = 0; i < 4; i++) begin
            step4(0, 4'b0000, 0, 1, stream[i][0], m);
            check($sformatf("gap_m%0d", i + 1), m, (i == 3) ? 1 : 0);
            if (i < 3) begin
                for (int g = 0; g < 3; g++) begin
                    step4(0, 4'b0000, 0, 0, (g % 2 == 0) ? 1'b1 : 1'b0, m);
                    check($sformatf("gap_idle_m%0d_%0d", i + 1, g), m, 0);
                    check($sformatf("gap_fill%0d_%0d", i + 1, g), if4.fill, i + 1);
                end
            end
        end
        check("gap_count", if4.match_count, 1);

        // Load while in HUNT with a would-be match on the same cycle.
        step4(1, 4'b1011, 1, 0, 0, m);
        for (int i = 0; i < 6; i++) step4(0, 4'b0000, 0, 1, stream[i][0], m);
        check("ld_pre_count", if4.match_count, 1);
        check("ld_pre_estados", if4.estados, 2);
        step4(1, 4'b0000, 1, 1, 1, m);
        check("ld_match", m, 0);
        check("ld_count", if4.match_count, 0);
        check("ld_fill", if4.fill, 0);
        check("ld_estados", if4.estados, 1);

        // All-zero pattern, overlapping: eight zeros give matches on bits 4..8.
        for (int i = 0; i < 8; i++) begin
            step4(0, 4'b0000, 0, 1, 0, m);
            check($sformatf("zero_m%0d", i + 1), m, (i >= 3) ? 1 : 0);
        end
        check("zero_count", if4.match_count, 5);
        check("zero_estados", if4.estados, 2);

        // Asynchronous reset between edges.
        if4.load = 1'b0; if4.data_valid = 1'b1; if4.data_in = 1'b0;
        #1 check("arst_pre_match", if4.match, 1);
        reset_n = 1'b0;
        #1;
        check("arst_estados", if4.estados, 0);
        check("arst_count", if4.match_count, 0);
        check("arst_match", if4.match, 0);
        check("arst_fill", if4.fill, 0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            step4(0, 4'b0000, 0, 1, 0, m);
            check($sformatf("post_rst_m%0d", i), m, 0);
            check($sformatf("post_rst_st%0d", i), if4.estados, 0);
            check($sformatf("post_rst_cnt%0d", i), if4.match_count, 0);
        end

        // Saturation on the 2-bit counter, PAT_W=2.
        step2(1, 2'b11, 1, 0, 0, m);
        for (int i = 0; i < 8; i++) begin
            step2(0, 2'b00, 0, 1, 1, m);
            check($sformatf("sat_m%0d", i + 1), m, (i >= 1) ? 1 : 0);
            check($sformatf("sat_cnt%0d", i + 1), if2.match_count, (i > 3) ? 3 : i);
            check($sformatf("sat_flag%0d", i + 1), if2.count_sat, (i >= 3) ? 1 : 0);
            check($sformatf("sat_st%0d", i + 1), if2.estados, 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
